comparator_scan_controller: RTL and testbench

Threshold-scan sequencer driving the comparator pulse injector and the threshold DAC. On `start` it clears the injector error counters, then steps the DAC from `thresh_start` to `thresh_stop`. At each point it fires `pulses_per_point` injector pulses through the `fire_pulse`/`pulser_ready` handshake, counts comparator hits from `compout_last`, and emits one result word per threshold point. It sits between the register interface and the injector/DAC serializer.

---
 rtl/comparator_scan_controller.sv | 162 ++++++++++++++++
 tb/tb_comparator_scan_controller.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_scan_controller.sv
// Threshold-scan sequencer: clears the injector error counters, then steps the
// threshold DAC across a range, fires a burst of injector pulses per point and reports the hit count.
module comparator_scan_controller #(
    parameter int DAC_BITS = 10,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [DAC_BITS-1:0] thresh_start,
    input  logic [DAC_BITS-1:0] thresh_stop,
    input  logic [DAC_BITS-1:0] thresh_step,
    input  logic [CNT_BITS-1:0] pulses_per_point,
    input  logic [7:0]          settle_cycles,
    output logic [DAC_BITS-1:0] dac_value,
    output logic                dac_load,
    input  logic                dac_busy,
    output logic                fire_pulse,
    input  logic                pulser_ready,
    input  logic                compout_last,
    output logic                errcnt_rst,
    output logic                result_valid,
    output logic [DAC_BITS-1:0] result_thresh,
    output logic [CNT_BITS-1:0] result_hits,
    output logic                busy,
    output logic                done,
    output logic                timeout
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_CLEAR     = 4'd1;
    localparam logic [3:0] S_LOAD      = 4'd2;
    localparam logic [3:0] S_DACWAIT   = 4'd3;
    localparam logic [3:0] S_SETTLE    = 4'd4;
    localparam logic [3:0] S_FIRE      = 4'd5;
    localparam logic [3:0] S_WAIT_ACK  = 4'd6;
    localparam logic [3:0] S_WAIT_DONE = 4'd7;
    localparam logic [3:0] S_REPORT    = 4'd8;
    localparam logic [3:0] S_NEXT      = 4'd9;
    localparam logic [3:0] S_FINISH    = 4'd10;

    logic [3:0]          state;
    logic [3:0]          next_state;
    logic [DAC_BITS-1:0] start_l;
    logic [DAC_BITS-1:0] stop_l;
    logic [DAC_BITS-1:0] step_l;
    logic [CNT_BITS-1:0] ppp_l;
    logic [CNT_BITS-1:0] pulse_cnt;
    logic [CNT_BITS-1:0] hit_cnt;
    logic [7:0]          settle_l;
    logic [7:0]          settle_cnt;
    logic [7:0]          wait_cnt;
    logic [DAC_BITS:0]   next_thresh;
    logic                range_end;
    logic                settle_done;
    logic                ack_timeout;

    // The extra top bit of next_thresh catches wrap-around past the top DAC code.
    assign next_thresh = {1'b0, dac_value} + {1'b0, step_l};
    assign range_end   = (dac_value == stop_l) || (next_thresh > {1'b0, stop_l}) || next_thresh[DAC_BITS];
    assign settle_done = (settle_cnt <= 8'd1);
    assign ack_timeout = (wait_cnt == 8'd254);

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (start && !abort) next_state = (thresh_start > thresh_stop) ? S_FINISH : S_CLEAR;
            S_CLEAR:     next_state = S_LOAD;
            S_LOAD:      if (dac_load) next_state = S_DACWAIT;
            S_DACWAIT:   if (!dac_busy) next_state = S_SETTLE;
            S_SETTLE:    if (settle_done) next_state = S_FIRE;
            S_FIRE:      next_state = (pulse_cnt == ppp_l) ? S_REPORT : S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (!pulser_ready)    next_state = S_WAIT_DONE;
                else if (ack_timeout) next_state = S_FINISH;
            end
            S_WAIT_DONE: if (pulser_ready) next_state = S_FIRE;
            S_REPORT:    next_state = S_NEXT;
            S_NEXT:      next_state = range_end ? S_FINISH : S_LOAD;
            S_FINISH:    next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
        if (abort && (state != S_IDLE) && (state != S_FINISH)) next_state = S_FINISH;
    end

    // Outputs are registered from the next state, so each strobe lines up with the state it belongs to.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            errcnt_rst    <= 1'b0;
            fire_pulse    <= 1'b0;
            dac_load      <= 1'b0;
            dac_value     <= '0;
            result_valid  <= 1'b0;
            result_thresh <= '0;
            result_hits   <= '0;
            timeout       <= 1'b0;
            start_l       <= '0;
            stop_l        <= '0;
            step_l        <= '0;
            ppp_l         <= '0;
            settle_l      <= '0;
            settle_cnt    <= '0;
            wait_cnt      <= '0;
            pulse_cnt     <= '0;
            hit_cnt       <= '0;
        end else begin
            state        <= next_state;
            busy         <= (next_state != S_IDLE);
            done         <= (next_state == S_FINISH);
            errcnt_rst   <= (next_state == S_CLEAR);
            fire_pulse   <= (next_state == S_WAIT_ACK);
            dac_load     <= (next_state == S_LOAD) && !dac_busy;
            result_valid <= (next_state == S_REPORT);
            if (next_state == S_REPORT) begin
                result_thresh <= dac_value;
                result_hits   <= hit_cnt;
            end

            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        start_l  <= thresh_start;
                        stop_l   <= thresh_stop;
                        step_l   <= (thresh_step == '0) ? {{(DAC_BITS-1){1'b0}}, 1'b1} : thresh_step;
                        ppp_l    <= pulses_per_point;
                        settle_l <= settle_cycles;
                        if (thresh_start <= thresh_stop) timeout <= 1'b0;
                    end
                end
                S_CLEAR:   dac_value <= start_l;
                S_DACWAIT: settle_cnt <= settle_l;
                S_SETTLE: begin
                    if (!settle_done) settle_cnt <= settle_cnt - 8'd1;
                    hit_cnt   <= '0;
                    pulse_cnt <= '0;
                end
                S_FIRE: wait_cnt <= '0;
                S_WAIT_ACK: begin
                    if (pulser_ready) begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (ack_timeout && !abort) timeout <= 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (pulser_ready && !abort) begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                        if (compout_last && (hit_cnt != {CNT_BITS{1'b1}})) hit_cnt <= hit_cnt + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (!range_end && !abort) dac_value <= next_thresh[DAC_BITS-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_scan_controller.sv
// Bench for comparator_scan_controller: models the injector and DAC serializer,
// predicts the result stream from the scan rules and checks it every cycle.
module tb_comparator_scan_controller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [9:0]  thresh_start = '0;
    logic [9:0]  thresh_stop = '0;
    logic [9:0]  thresh_step = '0;
    logic [15:0] pulses_per_point = '0;
    logic [7:0]  settle_cycles = '0;
    logic        dac_busy = 1'b0;
    logic        pulser_ready = 1'b1;
    logic        compout_last = 1'b0;
    logic [9:0]  dac_value;
    logic        dac_load;
    logic        fire_pulse;
    logic        errcnt_rst;
    logic        result_valid;
    logic [9:0]  result_thresh;
    logic [15:0] result_hits;
    logic        busy;
    logic        done;
    logic        timeout;

    int total = 0;
    int bad = 0;
    int fire_cnt, load_cnt, res_cnt, done_cnt, errcnt_cnt, busy_cycles, fire_high;
    int pulse_idx, inj_cnt, dac_busy_cnt;
    int mode = 0;
    bit stuck = 1'b0;
    bit prev_done = 1'b0;
    int exp_thr[$];
    int exp_hit[$];

    comparator_scan_controller #(.DAC_BITS(10), .CNT_BITS(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .thresh_start(thresh_start), .thresh_stop(thresh_stop), .thresh_step(thresh_step),
        .pulses_per_point(pulses_per_point), .settle_cycles(settle_cycles),
        .dac_value(dac_value), .dac_load(dac_load), .dac_busy(dac_busy),
        .fire_pulse(fire_pulse), .pulser_ready(pulser_ready), .compout_last(compout_last),
        .errcnt_rst(errcnt_rst), .result_valid(result_valid), .result_thresh(result_thresh),
        .result_hits(result_hits), .busy(busy), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Comparator outcome of the i-th pulse of a scan.
    function automatic int pat(input int i);
        if (mode == 0) return 1;
        return ((i % 3) != 2) ? 1 : 0;
    endfunction

    // Expected result list straight from the scan rules.
    task automatic buildModel(input int s, input int e, input int st, input int p);
        int v;
        int k;
        int h;
        exp_thr.delete();
        exp_hit.delete();
        if (st == 0) st = 1;
        if (s > e) return;
        v = s;
        k = 0;
        forever begin
            h = 0;
            for (int i = k * p; i < (k + 1) * p; i++) h += pat(i);
            exp_thr.push_back(v);
            exp_hit.push_back(h);
            if (v == e || v + st > e) break;
            v += st;
            k++;
        end
    endtask

    task automatic clearCounters();
        fire_cnt = 0; load_cnt = 0; res_cnt = 0; done_cnt = 0;
        errcnt_cnt = 0; busy_cycles = 0; fire_high = 0; pulse_idx = 0;
    endtask

    task automatic applyStimulus(input int s, input int e, input int st, input int p, input int set, input int m);
        @(negedge clk);
        thresh_start = 10'(s);
        thresh_stop = 10'(e);
        thresh_step = 10'(st);
        pulses_per_point = 16'(p);
        settle_cycles = 8'(set);
        mode = m;
        buildModel(s, e, st, p);
        clearCounters();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        for (int c = 0; c < budget && done_cnt == 0; c++) @(negedge clk);
        if (done_cnt == 0) checkOutput("scan_done_timeout", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
        checkOutput({tag, "_fire"}, int'(fire_pulse), 0);
        checkOutput({tag, "_dac_load"}, int'(dac_load), 0);
        checkOutput({tag, "_errcnt_rst"}, int'(errcnt_rst), 0);
        checkOutput({tag, "_result_valid"}, int'(result_valid), 0);
        checkOutput({tag, "_dac_value"}, int'(dac_value), 0);
        checkOutput({tag, "_result_thresh"}, int'(result_thresh), 0);
        checkOutput({tag, "_result_hits"}, int'(result_hits), 0);
        checkOutput({tag, "_timeout"}, int'(timeout), 0);
    endtask

    // Injector and DAC serializer models, plus the no-refire check.
    always @(negedge clk) begin
        if (!reset_n) begin
            pulser_ready = 1'b1;
            inj_cnt = 0;
            dac_busy = 1'b0;
            dac_busy_cnt = 0;
        end else begin
            if (inj_cnt > 0) begin
                checkOutput("fire_held_after_ack", int'(fire_pulse), 0);
                inj_cnt--;
                if (inj_cnt == 0) begin
                    compout_last = (pat(pulse_idx) != 0);
                    pulse_idx++;
                    pulser_ready = 1'b1;
                end
            end else if (fire_pulse && !stuck) begin
                pulser_ready = 1'b0;
                inj_cnt = 2;
                fire_cnt++;
            end
            if (dac_load) begin
                dac_busy = 1'b1;
                dac_busy_cnt = 3;
            end else if (dac_busy_cnt > 0) begin
                dac_busy_cnt--;
                if (dac_busy_cnt == 0) dac_busy = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            if (busy) busy_cycles++;
            if (fire_pulse) fire_high++;
            if (errcnt_rst) errcnt_cnt++;
            if (prev_done) checkOutput("busy_after_done", int'(busy), 0);
            prev_done = done;
            if (done) done_cnt++;
            if (dac_load) begin
                if (load_cnt < exp_thr.size()) checkOutput("load_value", int'(dac_value), exp_thr[load_cnt]);
                else checkOutput("load_extra", 1, 0);
                load_cnt++;
            end
            if (result_valid) begin
                if (res_cnt < exp_thr.size()) begin
                    checkOutput("result_thresh", int'(result_thresh), exp_thr[res_cnt]);
                    checkOutput("result_hits", int'(result_hits), exp_hit[res_cnt]);
                end else checkOutput("result_extra", 1, 0);
                res_cnt++;
            end
        end else begin
            prev_done = 1'b0;
        end
    end

    initial begin
        clearCounters();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] scan 10..14 step 2, 3 pulses");
        applyStimulus(10, 14, 2, 3, 4, 0);
        checkOutput("model_a_size", exp_thr.size(), 3);
        checkOutput("model_a_t0", exp_thr[0], 10);
        checkOutput("model_a_t2", exp_thr[2], 14);
        checkOutput("model_a_h1", exp_hit[1], 3);
        waitDone(3000);
        checkOutput("a_results", res_cnt, 3);
        checkOutput("a_fires", fire_cnt, 9);
        checkOutput("a_loads", load_cnt, 3);
        checkOutput("a_errcnt", errcnt_cnt, 1);
        checkOutput("a_done", done_cnt, 1);
        checkOutput("a_timeout", int'(timeout), 0);

        $display("[TB] scan near top code");
        applyStimulus(1022, 1023, 4, 1, 0, 0);
        checkOutput("model_b_size", exp_thr.size(), 1);
        checkOutput("model_b_t0", exp_thr[0], 1022);
        waitDone(1000);
        checkOutput("b_results", res_cnt, 1);
        checkOutput("b_done", done_cnt, 1);
        checkOutput("b_timeout", int'(timeout), 0);

        $display("[TB] empty range");
        applyStimulus(5, 3, 1, 1, 0, 0);
        checkOutput("model_c_size", exp_thr.size(), 0);
        waitDone(100);
        checkOutput("c_busy_cycles", busy_cycles, 1);
        checkOutput("c_done", done_cnt, 1);
        checkOutput("c_errcnt", errcnt_cnt, 0);
        checkOutput("c_loads", load_cnt, 0);
        checkOutput("c_results", res_cnt, 0);

        $display("[TB] start with abort in idle");
        clearCounters();
        thresh_start = 10'd1;
        thresh_stop = 10'd2;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("d_busy_cycles", busy_cycles, 0);
        checkOutput("d_done", done_cnt, 0);
        checkOutput("d_errcnt", errcnt_cnt, 0);

        $display("[TB] injector never acknowledges");
        stuck = 1'b1;
        applyStimulus(30, 31, 1, 2, 0, 0);
        waitDone(1000);
        stuck = 1'b0;
        checkOutput("e_fire_high", fire_high, 255);
        checkOutput("e_timeout", int'(timeout), 1);
        checkOutput("e_fire_low", int'(fire_pulse), 0);
        checkOutput("e_done", done_cnt, 1);
        checkOutput("e_results", res_cnt, 0);

        $display("[TB] step 0, mixed comparator outcomes");
        applyStimulus(7, 9, 0, 2, 0, 1);
        checkOutput("f_timeout_cleared", int'(timeout), 0);
        checkOutput("model_f_size", exp_thr.size(), 3);
        checkOutput("model_f_h0", exp_hit[0], 2);
        checkOutput("model_f_h1", exp_hit[1], 1);
        checkOutput("model_f_h2", exp_hit[2], 1);
        waitDone(2000);
        checkOutput("f_results", res_cnt, 3);
        checkOutput("f_fires", fire_cnt, 6);

        $display("[TB] zero pulses per point");
        applyStimulus(20, 22, 1, 0, 2, 0);
        checkOutput("model_g_h0", exp_hit[0], 0);
        waitDone(1000);
        checkOutput("g_fires", fire_cnt, 0);
        checkOutput("g_results", res_cnt, 3);
        checkOutput("g_loads", load_cnt, 3);

        $display("[TB] abort during point 2");
        applyStimulus(0, 3, 1, 2, 1, 0);
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 500 && fire_cnt < 3; c++) @(negedge clk);
        checkOutput("h_reached_point2", int'(fire_cnt >= 3), 1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("h_done_after_abort", int'(done), 1);
        repeat (10) @(negedge clk);
        checkOutput("h_results", res_cnt, 1);
        checkOutput("h_done_count", done_cnt, 1);
        checkOutput("h_errcnt", errcnt_cnt, 1);
        checkOutput("h_loads", load_cnt, 2);

        $display("[TB] reset during settle");
        applyStimulus(100, 102, 1, 1, 50, 0);
        for (int c = 0; c < 100 && load_cnt < 1; c++) @(negedge clk);
        repeat (6) @(negedge clk);
        checkOutput("i_dac_value_before_reset", int'(dac_value), 100);
        reset_n = 1'b0;
        @(negedge clk);
        checkAllZero("midscan_reset");
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("i_no_done", done_cnt, 0);
        checkOutput("i_idle", int'(busy), 0);
        applyStimulus(10, 14, 2, 3, 4, 0);
        waitDone(3000);
        checkOutput("i_rescan_results", res_cnt, 3);
        checkOutput("i_rescan_done", done_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
